// File: rtl/decode_stage_pipelined_pkg.sv
// Shared decode definitions: opcodes, ALUOp codes, ex_ctrl bit positions.
// Used by decode_stage_pipelined and its testbench.
package decode_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    localparam int C_ALUSRC   = 7;
    localparam int C_MEM2REG  = 6;
    localparam int C_REGWRITE = 5;
    localparam int C_MEMREAD  = 4;
    localparam int C_MEMWRITE = 3;
    localparam int C_BRANCH   = 2;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic [7:0] pack_ctrl(ctrl_t c);
        logic [7:0] r;
        r             = '0;
        r[C_ALUSRC]   = c.alu_src;
        r[C_MEM2REG]  = c.mem_to_reg;
        r[C_REGWRITE] = c.reg_write;
        r[C_MEMREAD]  = c.mem_read;
        r[C_MEMWRITE] = c.mem_write;
        r[C_BRANCH]   = c.branch;
        r[1:0]        = c.alu_op;
        return r;
    endfunction

endpackage

// File: rtl/decode_stage_pipelined_if.sv
// IF/ID, WB and ID/EX signal bundle for the decode stage.
// master = surrounding pipeline, slave = decode stage.
interface decode_stage_pipelined_if #(
    parameter int XLEN   = 32,
    parameter int IMM_W  = 64,
    parameter int REG_AW = 5
);
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [31:0]       if_instr;
    logic              id_ready;
    logic              flush;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [IMM_W-1:0]  ex_imm;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [3:0]        ex_alu_ctrl;
    logic [7:0]        ex_ctrl;

    modport master (
        output if_valid, if_pc, if_instr, flush,
        output wb_we, wb_addr, wb_data,
        input  id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
        input  ex_imm, ex_rd, ex_rs1, ex_rs2, ex_alu_ctrl, ex_ctrl
    );

    modport slave (
        input  if_valid, if_pc, if_instr, flush,
        input  wb_we, wb_addr, wb_data,
        output id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
        output ex_imm, ex_rd, ex_rs1, ex_rs2, ex_alu_ctrl, ex_ctrl
    );
endinterface

// File: rtl/decode_stage_pipelined_regfile_nr.sv
// NREG x XLEN register file, x0 hardwired to zero, async reset.
// DECODE_WB_BYPASS_EN: same-cycle write is visible on the read ports.
module regfile_nr #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);
    logic [XLEN-1:0] regs [NREG];
    logic            wok, ok1, ok2, byp1, byp2;

    assign wok = we && waddr != '0 && int'(waddr) < NREG;
    assign ok1 = raddr1 != '0 && int'(raddr1) < NREG;
    assign ok2 = raddr2 != '0 && int'(raddr2) < NREG;

`ifdef DECODE_WB_BYPASS_EN
    assign byp1 = we && waddr == raddr1;
    assign byp2 = we && waddr == raddr2;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wok) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = !ok1 ? '0 : byp1 ? wdata : regs[raddr1];
    assign rdata2 = !ok2 ? '0 : byp2 ? wdata : regs[raddr2];
endmodule

// File: rtl/decode_stage_pipelined.sv
// Instruction decode stage with ID/EX register, load-use stall and flush.
// Optional macro DECODE_WB_BYPASS_EN enables write-first register reads.
module decode_stage_pipelined
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IMM_W  = 64,
    parameter int NREG   = 32,
    parameter int REG_AW = 5
) (
    input logic clk,
    input logic rst_n,
    decode_stage_pipelined_if.slave bus
);
    logic [31:0]       ins;
    logic [6:0]        opc;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   rd1, rd2;
    logic              is_r, is_i, is_ld, is_st, is_br;
    logic              legal, uses_rs2, hazard, load;
    ctrl_t             ctrl;
    logic [11:0]       imm12;
    logic [IMM_W-1:0]  imm;

    logic              v_q;
    logic [XLEN-1:0]   pc_q, d1_q, d2_q;
    logic [IMM_W-1:0]  imm_q;
    logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
    logic [3:0]        alu_q;
    logic [7:0]        ctrl_q;

    assign ins   = bus.if_instr;
    assign opc   = ins[6:0];
    assign rs1   = REG_AW'(ins[19:15]);
    assign rs2   = REG_AW'(ins[24:20]);
    assign rd    = REG_AW'(ins[11:7]);
    assign is_r  = opc == OPC_R;
    assign is_i  = opc == OPC_I;
    assign is_ld = opc == OPC_LOAD;
    assign is_st = opc == OPC_STORE;
    assign is_br = opc == OPC_BRANCH;

    always_comb begin
        ctrl  = '0;
        imm12 = '0;
        legal = 1'b1;
        unique case (1'b1)
            is_r: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FN;
            end
            is_i: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FN;
                imm12          = ins[31:20];
            end
            is_ld: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_MEM;
                imm12           = ins[31:20];
            end
            is_st: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_MEM;
                imm12          = {ins[31:25], ins[11:7]};
            end
            is_br: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_BR;
                imm12       = {ins[31], ins[7], ins[30:25], ins[11:8]};
            end
            default: legal = 1'b0;
        endcase
    end

    assign imm = {{(IMM_W-12){imm12[11]}}, imm12};

    regfile_nr #(
        .XLEN(XLEN), .NREG(NREG), .REG_AW(REG_AW)
    ) u_rf (
        .clk(clk), .rst_n(rst_n),
        .we(bus.wb_we), .waddr(bus.wb_addr), .wdata(bus.wb_data),
        .raddr1(rs1), .raddr2(rs2),
        .rdata1(rd1), .rdata2(rd2)
    );

    // rs2 only matters for formats that actually read it
    assign uses_rs2 = is_r || is_st || is_br;
    assign hazard   = v_q && ctrl_q[C_MEMREAD] && rd_q != '0 &&
                      (rd_q == rs1 || (rd_q == rs2 && uses_rs2));
    assign load     = !(bus.flush || hazard) && bus.if_valid && legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !load) begin
            v_q    <= 1'b0;
            pc_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            imm_q  <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            alu_q  <= '0;
            ctrl_q <= '0;
        end else begin
            v_q    <= 1'b1;
            pc_q   <= bus.if_pc;
            d1_q   <= rd1;
            d2_q   <= rd2;
            imm_q  <= imm;
            rd_q   <= rd;
            rs1_q  <= rs1;
            rs2_q  <= rs2;
            alu_q  <= {ins[30], ins[14:12]};
            ctrl_q <= pack_ctrl(ctrl);
        end
    end

    assign bus.id_ready    = !hazard;
    assign bus.ex_valid    = v_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rs1_data = d1_q;
    assign bus.ex_rs2_data = d2_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_rs1      = rs1_q;
    assign bus.ex_rs2      = rs2_q;
    assign bus.ex_alu_ctrl = alu_q;
    assign bus.ex_ctrl     = ctrl_q;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Scoreboard bench for decode_stage_pipelined: expected ID/EX contents are
// queued as each instruction is driven and compared one edge later.
module tb_decode_stage_pipelined;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  alu;
        logic [7:0]  ctrl;
    } exo_t;

    localparam logic [31:0] ADD_755 = 32'h005283B3;
    localparam logic [31:0] ADD_700 = 32'h000003B3;
    localparam logic [31:0] LD_6_2  = 32'h00813303;
    localparam logic [31:0] ADD_861 = 32'h00130433;
    localparam logic [31:0] ADDI_91 = 32'h00608493;
    localparam logic [31:0] BEQ_NEG = 32'hFE000EE3;
    localparam logic [31:0] SD_NEG8 = 32'hFE513C23;
    localparam logic [7:0]  K_R     = 8'b00100010;
    localparam logic [7:0]  K_I     = 8'b10100010;
    localparam logic [7:0]  K_LD    = 8'b11110000;
    localparam logic [7:0]  K_ST    = 8'b10001000;
    localparam logic [7:0]  K_BR    = 8'b00000101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exo_t sbq[$];

    decode_stage_pipelined_if bus();

    decode_stage_pipelined dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic exo_t mk(logic v, logic [31:0] pc, logic [31:0] d1,
                                logic [31:0] d2, logic [63:0] imm,
                                logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic [3:0] alu,
                                logic [7:0] ctrl);
        return '{v, pc, d1, d2, imm, rd, rs1, rs2, alu, ctrl};
    endfunction

    function automatic exo_t obs();
        return '{bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data,
                 bus.ex_imm, bus.ex_rd, bus.ex_rs1, bus.ex_rs2,
                 bus.ex_alu_ctrl, bus.ex_ctrl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [31:0] instr, logic [31:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc    = pc;
    endtask

    task automatic idle();
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;
    endtask

    task automatic wb(logic en, logic [4:0] a, logic [31:0] d);
        bus.wb_we   = en;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    task automatic test_wb_add();
        exo_t e, o;
        idle();
        wb(1'b1, 5'd5, 32'hDEADBEEF);
        sbq.push_back('0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL wb_idle got %h want %h", o, e); end
        drive(ADD_755, 32'h100);
        sbq.push_back(mk(1, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 0, 7, 5, 5, 0, K_R));
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL add_x5 got %h want %h", o, e); end
        idle();
    endtask

    task automatic test_reset();
        exo_t e, o;
        #2 rst_n = 1'b0;
        #1;
        sbq.push_back('0);
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_outs got %h want %h", o, e); end
        checks++;
        if (bus.id_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", bus.id_ready);
        end
        tick();
        rst_n = 1'b1;
        drive(ADD_755, 32'h104);
        sbq.push_back(mk(1, 32'h104, 0, 0, 0, 7, 5, 5, 0, K_R));
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_x5 got %h want %h", o, e); end
        idle();
    endtask

    task automatic test_bypass();
        exo_t e, o;
        logic [31:0] same;
`ifdef DECODE_WB_BYPASS_EN
        same = 32'h12345678;
`else
        same = 32'hA5A5A5A5;
`endif
        wb(1'b1, 5'd5, 32'hA5A5A5A5);
        sbq.push_back('0);
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL byp_pre got %h want %h", o, e); end
        wb(1'b1, 5'd5, 32'h12345678);
        drive(ADD_755, 32'h110);
        sbq.push_back(mk(1, 32'h110, same, same, 0, 7, 5, 5, 0, K_R));
        tick();
        wb(1'b0, 5'd0, 32'h0);
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL byp_same got %h want %h", o, e); end
        drive(ADD_755, 32'h114);
        sbq.push_back(mk(1, 32'h114, 32'h12345678, 32'h12345678, 0, 7, 5, 5, 0, K_R));
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL byp_after got %h want %h", o, e); end
        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        drive(ADD_700, 32'h118);
        sbq.push_back(mk(1, 32'h118, 0, 0, 0, 7, 0, 0, 0, K_R));
        tick();
        wb(1'b0, 5'd0, 32'h0);
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL x0_same got %h want %h", o, e); end
        drive(ADD_700, 32'h11C);
        sbq.push_back(mk(1, 32'h11C, 0, 0, 0, 7, 0, 0, 0, K_R));
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL x0_after got %h want %h", o, e); end
        idle();
    endtask

    task automatic test_load_use();
        exo_t e, o;
        for (int i = 1; i <= 2; i++) begin
            wb(1'b1, 5'(i), 32'(i * 32'h11));
            sbq.push_back('0);
            tick();
            e = sbq.pop_front(); o = obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL lu_wb%0d got %h want %h", i, o, e); end
        end
        wb(1'b0, 5'd0, 32'h0);
        drive(LD_6_2, 32'h200);
        sbq.push_back(mk(1, 32'h200, 32'h22, 0, 8, 6, 2, 8, 4'b0011, K_LD));
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL ld got %h want %h", o, e); end
        drive(ADD_861, 32'h204);
        #1; checks++;
        if (bus.id_ready !== 1'b0) begin
            errors++; $display("FAIL lu_stall got %b want 0", bus.id_ready);
        end
        sbq.push_back('0);
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL lu_bubble got %h want %h", o, e); end
        checks++;
        if (bus.id_ready !== 1'b1) begin
            errors++; $display("FAIL lu_release got %b want 1", bus.id_ready);
        end
        sbq.push_back(mk(1, 32'h204, 0, 32'h11, 0, 8, 6, 1, 0, K_R));
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL lu_add got %h want %h", o, e); end
        drive(LD_6_2, 32'h208);
        sbq.push_back(mk(1, 32'h208, 32'h22, 0, 8, 6, 2, 8, 4'b0011, K_LD));
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL ld2 got %h want %h", o, e); end
        drive(ADDI_91, 32'h20C);
        #1; checks++;
        if (bus.id_ready !== 1'b1) begin
            errors++; $display("FAIL nostall_ready got %b want 1", bus.id_ready);
        end
        sbq.push_back(mk(1, 32'h20C, 32'h11, 0, 6, 9, 1, 6, 0, K_I));
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL addi_nostall got %h want %h", o, e); end
        idle();
    endtask

    task automatic test_flush();
        exo_t e, o;
        drive(LD_6_2, 32'h300);
        sbq.push_back(mk(1, 32'h300, 32'h22, 0, 8, 6, 2, 8, 4'b0011, K_LD));
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL fl_ld got %h want %h", o, e); end
        drive(ADD_861, 32'h304);
        bus.flush = 1'b1;
        #1; checks++;
        if (bus.id_ready !== 1'b0) begin
            errors++; $display("FAIL fl_stall got %b want 0", bus.id_ready);
        end
        sbq.push_back('0);
        tick();
        bus.flush = 1'b0;
        idle();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL fl_bubble got %h want %h", o, e); end
        sbq.push_back('0);
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL fl_next got %h want %h", o, e); end
        drive(ADD_755, 32'h310);
        bus.flush = 1'b1;
        sbq.push_back('0);
        tick();
        bus.flush = 1'b0;
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL fl_squash got %h want %h", o, e); end
        idle();
    endtask

    task automatic test_imm();
        exo_t e, o;
        drive(BEQ_NEG, 32'h400);
        sbq.push_back(mk(1, 32'h400, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 29, 0, 0, 4'b1000, K_BR));
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL imm_b got %h want %h", o, e); end
        drive(SD_NEG8, 32'h404);
        sbq.push_back(mk(1, 32'h404, 32'h22, 32'h12345678, 64'hFFFF_FFFF_FFFF_FFF8,
                         24, 2, 5, 4'b1011, K_ST));
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL imm_s got %h want %h", o, e); end
        drive(32'h0000007F, 32'h408);
        sbq.push_back('0);
        tick();
        e = sbq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL bad_opc got %h want %h", o, e); end
        idle();
    endtask

    initial begin
        idle();
        bus.flush = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        test_wb_add();
        test_reset();
        test_bypass();
        test_load_use();
        test_flush();
        test_imm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
